// File: rtl/cic_decimator_param_if.sv
// Bus between the bitstream source and the CIC decimator.
// out_valid is a single-cycle strobe with no backpressure: the consumer must take out_data on every cycle it is high.
interface cic_decimator_param_if #(
    parameter int OUT_W = 16
);
    logic             en;
    logic [2:0]       dec_log2;
    logic             in_bit;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;

    modport master (
        output en, dec_log2, in_bit,
        input  out_data, out_valid
    );

    modport slave (
        input  en, dec_log2, in_bit,
        output out_data, out_valid
    );
endinterface

// File: rtl/cic_decimator_param.sv
// Single-clock CIC decimator for a 1-bit delta-sigma stream, runtime ratio R = 2^k.
// Define CIC_BIPOLAR_EN for +1/-1 input mapping and a two's complement output.
module cic_decimator_param #(
    parameter int ORDER     = 3,
    parameter int MAX_LOG2R = 6,
    parameter int OUT_W     = 16
) (
    input logic                  clk,
    input logic                  rst_n,
    cic_decimator_param_if.slave bus
);
`ifdef CIC_BIPOLAR_EN
    localparam int BIP_W = 2;
    localparam int IN_W  = 2;
`else
    localparam int BIP_W = 1;
    localparam int IN_W  = 1;
`endif
    localparam int ACC_W = ORDER * MAX_LOG2R + BIP_W;

    logic [2:0]             k_reg;
    logic [2:0]             k_clamp;
    logic [MAX_LOG2R-1:0]   cnt;
    logic [MAX_LOG2R-1:0]   cnt_last;
    logic [2:0]             disc;
    logic [IN_W-1:0]        x_in;
    logic [IN_W-1:0]        in_reg;
    logic [ACC_W-1:0]       x_ext;
    logic [ACC_W-1:0]       integ [ORDER];
    logic [ACC_W-1:0]       dly [ORDER];
    logic [ACC_W-1:0]       comb_in [ORDER];
    logic [ACC_W-1:0]       c_n;
    logic [ACC_W+OUT_W-1:0] c_wide;
    logic [OUT_W-1:0]       norm;
    logic [OUT_W-1:0]       out_data_r;
    logic                   out_valid_r;
    logic                   clear;
    logic                   dec_event;

    always_comb begin
        k_clamp = bus.dec_log2;
        if (bus.dec_log2 == 3'd0) begin
            k_clamp = 3'd1;
        end else if (int'(bus.dec_log2) > MAX_LOG2R) begin
            k_clamp = 3'(MAX_LOG2R);
        end
    end

    // A ratio change clears the datapath exactly like en=0 and restarts discard.
    assign clear     = (k_clamp != k_reg) || !bus.en;
    assign cnt_last  = ~({MAX_LOG2R{1'b1}} << k_reg);
    assign dec_event = (cnt == cnt_last);

`ifdef CIC_BIPOLAR_EN
    assign x_in   = bus.in_bit ? 2'b01 : 2'b11;
    assign x_ext  = {{(ACC_W-2){in_reg[1]}}, in_reg};
    assign c_wide = {{OUT_W{c_n[ACC_W-1]}}, c_n};
`else
    assign x_in   = bus.in_bit;
    assign x_ext  = {{(ACC_W-1){1'b0}}, in_reg};
    assign c_wide = {{OUT_W{1'b0}}, c_n};
`endif

    always_comb begin
        c_n = integ[ORDER-1];
        for (int j = 0; j < ORDER; j++) begin
            comb_in[j] = c_n;
            c_n        = c_n - dly[j];
        end
    end

    // One fixed shift per legal k; k_reg only selects among them.
    always_comb begin
        norm = '0;
        for (int kk = 1; kk <= MAX_LOG2R; kk++) begin
            if (int'(k_reg) == kk) begin
                norm = OUT_W'((c_wide >> ((ORDER*kk+BIP_W > OUT_W) ? ORDER*kk+BIP_W-OUT_W : 0))
                              << ((ORDER*kk+BIP_W < OUT_W) ? OUT_W-ORDER*kk-BIP_W : 0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_reg       <= k_clamp;
            in_reg      <= '0;
            cnt         <= '0;
            disc        <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            for (int j = 0; j < ORDER; j++) begin
                integ[j] <= '0;
                dly[j]   <= '0;
            end
        end else begin
            k_reg       <= k_clamp;
            out_valid_r <= 1'b0;
            if (clear) begin
                in_reg <= '0;
                cnt    <= '0;
                disc   <= '0;
                for (int j = 0; j < ORDER; j++) begin
                    integ[j] <= '0;
                    dly[j]   <= '0;
                end
            end else begin
                in_reg   <= x_in;
                integ[0] <= integ[0] + x_ext;
                for (int j = 1; j < ORDER; j++) begin
                    integ[j] <= integ[j] + integ[j-1];
                end
                if (dec_event) begin
                    cnt <= '0;
                    for (int j = 0; j < ORDER; j++) begin
                        dly[j] <= comb_in[j];
                    end
                    // Startup transient: the first ORDER decimations are swallowed.
                    if (int'(disc) < ORDER) begin
                        disc <= disc + 1'b1;
                    end else begin
                        out_data_r  <= norm;
                        out_valid_r <= 1'b1;
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
endmodule

// File: tb/tb_cic_decimator_param.sv
// Bench for cic_decimator_param: random and directed bitstreams checked against a
// convolution-based CIC reference model through an expected-value queue.
module tb_cic_decimator_param;
    localparam int ORDER     = 3;
    localparam int MAX_LOG2R = 6;
    localparam int OUT_W     = 16;
`ifdef CIC_BIPOLAR_EN
    localparam int BIP = 1;
    localparam logic [OUT_W-1:0] EXP_ONE  = 16'h4000;
    localparam logic [OUT_W-1:0] EXP_ALT  = 16'h0000;
    localparam logic [OUT_W-1:0] EXP_ZERO = 16'hC000;
`else
    localparam int BIP = 0;
    localparam logic [OUT_W-1:0] EXP_ONE  = 16'h8000;
    localparam logic [OUT_W-1:0] EXP_ALT  = 16'h4000;
    localparam logic [OUT_W-1:0] EXP_ZERO = 16'h0000;
`endif
    localparam int HMAX = ORDER * ((1 << MAX_LOG2R) - 1) + 1;

    logic clk;
    logic rst_n;
    cic_decimator_param_if #(.OUT_W(OUT_W)) bus ();

    cic_decimator_param #(
        .ORDER(ORDER), .MAX_LOG2R(MAX_LOG2R), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    bit mon_on = 0;
    logic [OUT_W-1:0] hold_val = '0;
    logic [OUT_W-1:0] exp_q[$];
    int exp_cyc_q[$];
    logic [OUT_W-1:0] mon_exp;
    int mon_cyc;

    // Reference model: exact convolution of the input history with the CIC impulse response.
    int k_m = 1;
    int m_idx = 0;
    int disc_m = 0;
    int x_hist[$];
    longint h[HMAX];
    int h_len = 1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int clamp_k(input logic [2:0] d);
        if (d == 3'd0) return 1;
        if (int'(d) > MAX_LOG2R) return MAX_LOG2R;
        return int'(d);
    endfunction

    // Coefficients of (1 + z^-1 + ... + z^-(R-1))^ORDER.
    task automatic build_h(input int k);
        longint tmp[HMAX];
        int r;
        r = 1 << k;
        h = '{default: 0};
        h[0] = 1;
        h_len = 1;
        repeat (ORDER) begin
            for (int n = 0; n < h_len + r - 1; n++) begin
                tmp[n] = 0;
                for (int l = 0; l < r; l++) begin
                    if (n - l >= 0 && n - l < h_len) tmp[n] += h[n-l];
                end
            end
            h_len = h_len + r - 1;
            for (int n = 0; n < h_len; n++) h[n] = tmp[n];
        end
    endtask

    function automatic logic [OUT_W-1:0] normalise(input longint y, input int k);
        int w;
        logic [63:0] yv;
        w  = ORDER * k + 1 + BIP;
        yv = y;
        if (w >= OUT_W) return OUT_W'(yv >> (w - OUT_W));
        return OUT_W'(yv << (OUT_W - w));
    endfunction

    task automatic model_clear();
        m_idx  = 0;
        disc_m = 0;
        x_hist.delete();
    endtask

    // Predicts the effect of the upcoming clock edge for the given inputs.
    task automatic model_edge(input logic rst_v, input logic en_v, input logic [2:0] dl, input logic b);
        int kc;
        longint y;
        int i;
        kc = clamp_k(dl);
        if (!rst_v || kc != k_m) begin
            k_m = kc;
            build_h(kc);
            model_clear();
            return;
        end
        if (!en_v) begin
            model_clear();
            return;
        end
        x_hist.push_back(b ? 1 : (BIP != 0 ? -1 : 0));
        if (m_idx % (1 << k_m) == (1 << k_m) - 1) begin
            if (disc_m < ORDER) begin
                disc_m++;
            end else begin
                y = 0;
                for (int j = 0; j < h_len; j++) begin
                    i = m_idx - ORDER - 1 - j;
                    if (i >= 0) y += h[j] * longint'(x_hist[i]);
                end
                exp_q.push_back(normalise(y, k_m));
                exp_cyc_q.push_back(edge_cnt + 1);
            end
        end
        m_idx++;
    endtask

    task automatic step(input logic en_v, input logic [2:0] dl, input logic b);
        bus.en       = en_v;
        bus.dec_log2 = dl;
        bus.in_bit   = b;
        model_edge(1'b1, en_v, dl, b);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [2:0] dl, input int n);
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.dec_log2 = dl;
        bus.in_bit   = 1'b0;
        repeat (n) begin
            model_edge(1'b0, 1'b1, dl, 1'b0);
            @(posedge clk);
            #1;
            hold_val = '0;
        end
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got=%b exp=0", bus.out_valid);
        end
        checks++;
        if (bus.out_data !== '0) begin
            errors++;
            $display("FAIL reset_data got=%h exp=0000", bus.out_data);
        end
        rst_n = 1'b1;
    endtask

    task automatic check_const(input string name, input logic [OUT_W-1:0] e);
        checks++;
        if (bus.out_data !== e) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, bus.out_data, e);
        end
    endtask

    // Monitor: pops an expectation for every strobe, otherwise checks that out_data holds.
    always @(negedge clk) begin
        if (mon_on) begin
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe_unexpected cycle=%0d got=%h exp=no strobe", edge_cnt, bus.out_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_cyc = exp_cyc_q.pop_front();
                    if (bus.out_data !== mon_exp) begin
                        errors++;
                        $display("FAIL strobe_data cycle=%0d got=%h exp=%h", edge_cnt, bus.out_data, mon_exp);
                    end
                    checks++;
                    if (edge_cnt != mon_cyc) begin
                        errors++;
                        $display("FAIL strobe_timing got=%0d exp=%0d", edge_cnt, mon_cyc);
                    end
                    hold_val = mon_exp;
                end
            end else begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.out_data !== hold_val) begin
                    errors++;
                    $display("FAIL idle_hold cycle=%0d got=%b/%h exp=0/%h",
                             edge_cnt, bus.out_valid, bus.out_data, hold_val);
                end
                if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= edge_cnt) begin
                    checks++;
                    errors++;
                    $display("FAIL strobe_missing got=none exp=%h at cycle %0d", exp_q[0], exp_cyc_q[0]);
                    void'(exp_q.pop_front());
                    void'(exp_cyc_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [2:0] dl;
        int len;
        int dens;
        logic en_v;

        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.dec_log2 = 3'd6;
        bus.in_bit   = 1'b0;
        do_reset(3'd6, 3);
        mon_on = 1;

        repeat (512) step(1'b1, 3'd6, 1'b1);
        check_const("const_one_k6", EXP_ONE);
        for (int i = 0; i < 384; i++) step(1'b1, 3'd6, 1'((i + 1) & 1));
        check_const("alternating_k6", EXP_ALT);
        repeat (320) step(1'b1, 3'd6, 1'b0);
        check_const("const_zero_k6", EXP_ZERO);
        repeat (128) step(1'b1, 3'd4, 1'b1);
        check_const("const_one_k4", EXP_ONE);

        repeat (40) step(1'b1, 3'd0, 1'($urandom_range(0, 1)));
        repeat (384) step(1'b1, 3'd7, 1'($urandom_range(0, 1)));
        repeat (10) step(1'b0, 3'd7, 1'($urandom_range(0, 1)));
        repeat (384) step(1'b1, 3'd7, 1'b1);
        check_const("restart_const_one", EXP_ONE);

        do_reset(3'd3, 2);
        for (int s = 0; s < 10; s++) begin
            dl   = 3'($urandom_range(0, 7));
            len  = $urandom_range(150, 700);
            dens = $urandom_range(0, 100);
            for (int c = 0; c < len; c++) begin
                en_v = ($urandom_range(0, 249) != 0);
                step(en_v, dl, 1'($urandom_range(0, 99) < dens));
            end
        end

        repeat (3) step(1'b0, bus.dec_log2, 1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding_expected got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cic_decimator_param.md
Name: cic_decimator_param

Overview:
- Parametrised single-clock CIC decimation filter for a 1-bit delta-sigma bitstream.
- Order, maximum decimation ratio and output width are parameters. The ratio is selectable at runtime as a power of two.
- There is no divided clock. Decimation uses an internal counter and a one-cycle output valid strobe.
- The block sits between the 1-bit modulator input pin and the parallel output pins, or a downstream FIR.

Parameters:
- ORDER, 3, number of integrator and comb stages (N), legal range 1..5.
- MAX_LOG2R, 6, maximum log2 of the decimation ratio; R = 2^k, k in 1..MAX_LOG2R.
- OUT_W, 16, output word width.
- ACC_W (localparam), ORDER*MAX_LOG2R+1, internal accumulator width (+2 with CIC_BIPOLAR_EN).

Ports:
- clk  in  1  system clock; one input bit sampled per enabled cycle.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  run enable; low clears the datapath and holds it idle.
- dec_log2  in  3  selects k, the log2 of the decimation ratio.
- in_bit  in  1  modulator bitstream.
- out_data  out  OUT_W  normalised decimated sample.
- out_valid  out  1  one-cycle strobe marking a new out_data value.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Integrators, combs, comb delay registers, input register, decimation counter and discard counter are cleared.
  - Output registers: out_data=0, out_valid=0.
  - k_reg is loaded with the clamped dec_log2.
- k clamping: dec_log2=0 gives k=1; dec_log2>MAX_LOG2R gives k=MAX_LOG2R.
- Input mapping: x = in_bit (0/1, unsigned), zero-extended to ACC_W.
- Each cycle with en=1:
  - in_reg <= x.
  - I1 <= I1 + in_reg.
  - Ij <= Ij + I(j-1) for j = 2..N, using the registered values from the previous cycle.
  - cnt increments by 1 and wraps from R-1 to 0.
- Accumulator arithmetic is modulo 2^ACC_W. Wrap-around is intended and must not saturate.
- Decimation event, on an enabled cycle with cnt==R-1:
  - C0 = I_N (current registered value).
  - Cj = C(j-1) - D_j, then D_j <= C(j-1), for j = 1..N.
  - The N comb differences are computed combinationally in this cycle.
  - C_N is normalised and registered into out_data at the same edge.
- out_valid is high for exactly the cycle after a decimation event. It stays 0 while the discard counter is below N.
- Discard counter: the first N decimation events after reset, en rising, or a k change update the counter only. out_data holds its previous value and no strobe is issued (startup transient).
- Normalisation: full scale is 2^(N*k), which fits in W = N*k+1 bits.
  - If W >= OUT_W: out_data = C_N[W-1 : W-OUT_W].
  - If W < OUT_W: out_data = C_N << (OUT_W-W).
  - The shift amount depends on k_reg and is a mux, not a barrel shifter across all widths.
- en=0:
  - Integrators, combs, in_reg, cnt and discard counter are cleared every cycle.
  - out_valid=0; out_data holds its last value.
- dec_log2 change while en=1:
  - The clamped value is compared with k_reg every cycle. On mismatch, k_reg updates and the datapath performs the same clear as en=0 for that cycle.
  - out_valid is forced 0 that cycle.
  - Discard then restarts.
- Simultaneous events: rst_n=0 overrides en and a k change. A k change overrides a coincident decimation event, so no output is produced for that event.
- Throughput: one output per R enabled cycles. There is no backpressure, and downstream must accept every strobe.

Optional Feature:
- Macro CIC_BIPOLAR_EN.
- Defined:
  - in_bit maps to +1 (1) or -1 (0), sign-extended.
  - ACC_W = ORDER*MAX_LOG2R+2 and W = N*k+2.
  - out_data is two's complement and is taken as the top OUT_W bits of the W-bit signed C_N, or left-shifted when W < OUT_W.
- Undefined: unsigned 0/1 mapping as specified above. This is the default build.

Test Plan (ORDER=3, MAX_LOG2R=6, OUT_W=16 unless stated):
- Reset, en=1, k=6, in_bit constant 1 → first 3 decimation events give no strobe; then out_valid pulses every 64 cycles with out_data=0x8000.
- k=6, alternating 1010… → steady out_data=0x4000. Constant 0 → out_data=0x0000 with strobes continuing.
- Change dec_log2 6→4 mid-stream with in_bit=1 → one clear cycle, 3 silent decimations, then strobes every 16 cycles with out_data=0x8000 (13-bit result shifted left by 3).
- dec_log2=0 → behaves as k=1 (strobe every 2 cycles). dec_log2=7 → behaves as k=6.
- en low for 10 cycles mid-stream → no strobes, out_data held. On en high, the discard sequence repeats and the output matches a fresh start.
- CIC_BIPOLAR_EN, k=6, in_bit=1 → out_data=0x4000; in_bit=0 → 0xC000; 1010… → 0x0000. Random bitstream → bit-exact match against a reference model, including accumulator wrap.
